// File: rtl/rr_pkg.sv
// Shared types and helpers for the round-robin grant mux.
// Holds the FSM state encoding and the one-hot check.
package rr_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 8;
  localparam int MAX_N = 32;

  typedef enum logic [1:0] {
    IDLE,
    GNT,
    SEND
  } rr_mux_state_e;

  function automatic logic is_onehot(
    input logic [MAX_N-1:0] v
  );
    logic [MAX_N-1:0] low;
    low = v & (v - MAX_N'(1));
    return (v != '0) && (low == '0);
  endfunction

endpackage

// File: rtl/rr_grant_mux_onehot2bin.sv
// One-hot to binary index encoder.
// Flags whether the input is exactly one-hot.
module onehot2bin
  import rr_pkg::*;
#(
  parameter  int N = N_DEF,
  localparam int M = $clog2(N)
) (
  input  logic [N-1:0] oh,
  output logic [M-1:0] idx,
  output logic         onehot
);

  // OR together the indices of all set bits
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) begin
        idx = idx | M'(i);
      end
    end
  end

  assign onehot = is_onehot(MAX_N'(oh));

endmodule

// File: rtl/rr_grant_mux.sv
// Round-robin grant mux: N valid/ready channels
// into one registered output stream, one beat per grant.
module rr_grant_mux
  import rr_pkg::*;
#(
  parameter  int N = N_DEF,
  parameter  int W = W_DEF,
  localparam int M = $clog2(N)
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic [N-1:0]   i_valid,
  output logic [N-1:0]   o_ready,
  input  logic [N*W-1:0] i_data,
  output logic [N-1:0]   o_req,
  output logic           o_arb_en,
  input  logic [N-1:0]   i_gnt,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [W-1:0]   o_data,
  output logic [M-1:0]   o_src,
  output logic           o_err
);

  rr_mux_state_e state;

  logic [M-1:0] gnt_idx;
  logic         gnt_oh;
  logic         gnt_hit;
  logic         any_valid;
  logic [W-1:0] sel_data;

  onehot2bin #(
    .N (N)
  ) u_oh2bin (
    .oh     (i_gnt),
    .idx    (gnt_idx),
    .onehot (gnt_oh)
  );

  assign any_valid = |i_valid;
  assign o_req     = i_valid;
  assign gnt_hit   = gnt_oh & (|(i_gnt & i_valid));

  // AND-OR payload select masked by the grant
  always_comb begin
    sel_data = '0;
    for (int c = 0; c < N; c++) begin
      sel_data = sel_data
               | (i_data[c*W +: W] & {W{i_gnt[c]}});
    end
  end

  // Arbiter only advances in IDLE or on an accepted beat
  always_comb begin
    o_arb_en = 1'b0;
    unique case (state)
      IDLE:    o_arb_en = any_valid;
      SEND:    o_arb_en = i_ready & any_valid;
      default: o_arb_en = 1'b0;
    endcase
  end

  // Pop strobe to the granted channel, only in GNT
  always_comb begin
    o_ready = '0;
    if (state == GNT && gnt_hit) begin
      o_ready = i_gnt;
    end
  end

  // Grant FSM with registered output beat and sticky error
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state   <= IDLE;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_src   <= '0;
      o_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_valid) begin
            state <= GNT;
          end
        end
        GNT: begin
          if (gnt_hit) begin
            o_data  <= sel_data;
            o_src   <= gnt_idx;
            o_valid <= 1'b1;
            state   <= SEND;
          end else begin
            o_err <= 1'b1;
            state <= IDLE;
          end
        end
        SEND: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= any_valid ? GNT : IDLE;
          end
        end
        default: begin
          o_valid <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
